// File: rtl/acc_frame_sequencer.sv
// Sends the BIP accumulator over uart_tx as one framed packet per halt rising edge:
// HEADER, NBYTES data bytes LSB-first (top byte zero-padded), then the XOR checksum.
module acc_frame_sequencer #(
    parameter int              NBITS_D = 16,
    parameter int              DBIT    = 8,
    parameter logic [DBIT-1:0] HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NBITS_D-1:0] i_acc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int NBYTES = (NBITS_D + DBIT - 1) / DBIT;
    localparam int SW     = NBYTES * DBIT;
    localparam int IW     = $clog2(NBYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);
    localparam logic [IW-1:0] DATA_MAX = IW'(NBYTES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic            halt_d;
    logic            rise;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc;
    logic [SW-1:0]   shadow;
    logic [DBIT-1:0] csum;
    logic [DBIT-1:0] byte_nx;
    logic            more_data;

    function automatic logic [SW-1:0] pad_acc(input logic [NBITS_D-1:0] a);
        logic [SW-1:0] p;
        p = '0;
        p[NBITS_D-1:0] = a;
        return p;
    endfunction

    // Data byte k (1..NBYTES) of the shadow; anything else yields zero.
    function automatic logic [DBIT-1:0] data_byte(input logic [SW-1:0] s,
                                                  input logic [IW-1:0] k);
        logic [DBIT-1:0] r;
        r = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (k == IW'(b + 1)) r = s[b*DBIT +: DBIT];
        end
        return r;
    endfunction

    assign rise = i_halt & ~halt_d;

    always_comb begin
        idx_inc   = idx + 1'b1;
        more_data = (idx < DATA_MAX);
        byte_nx   = data_byte(shadow, idx_inc);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rise) state_nx = SEND;
            SEND: state_nx = WAIT;
            WAIT: if (i_tx_done) state_nx = (idx == LAST_IDX) ? DONE : SEND;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_tx_start   = (state == SEND);
        o_busy       = (state != IDLE);
        o_frame_done = (state == DONE);
    end

    // Frame datapath: capture on accept, advance one byte per tx_done in WAIT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            halt_d    <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
            csum      <= '0;
            o_tx_data <= '0;
        end else begin
            halt_d <= i_halt;
            if (state == IDLE && rise) begin
                shadow    <= pad_acc(i_acc);
                idx       <= '0;
                csum      <= HEADER;
                o_tx_data <= HEADER;
            end else if (state == WAIT && i_tx_done && idx != LAST_IDX) begin
                idx <= idx_inc;
                if (more_data) begin
                    csum      <= csum ^ byte_nx;
                    o_tx_data <= byte_nx;
                end else begin
                    o_tx_data <= csum;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_frame_sequencer.sv
// Bench for acc_frame_sequencer: a uart_tx stand-in answers each start pulse with a done pulse,
// and captured frames are compared against byte lists built from the frame rules.
module tb_acc_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_a = 1'b0, halt_b = 1'b0;
    logic [15:0] acc_a = '0;
    logic [10:0] acc_b = '0;
    logic        done_a, done_b;
    logic        start_a, start_b, busy_a, busy_b, fd_a, fd_b;
    logic [7:0]  data_a, data_b;

    logic        cur = 1'b0;
    logic        resp = 1'b0;
    logic        spur = 1'b0;
    int          dly = 20;
    int          cnt = 0;
    int          cyc = 0;

    int          total = 0;
    int          bad = 0;

    int          st_cyc[$];
    logic [7:0]  st_dat[$];
    int          dn_cyc[$];
    logic [7:0]  dn_dat[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    int          dbl = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  exp_q[$];

    wire       cur_start = cur ? start_b : start_a;
    wire       cur_busy  = cur ? busy_b  : busy_a;
    wire       cur_fd    = cur ? fd_b    : fd_a;
    wire [7:0] cur_data  = cur ? data_b  : data_a;

    assign done_a = ~cur & (resp | spur);
    assign done_b =  cur & (resp | spur);

    acc_frame_sequencer #(.NBITS_D(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_halt(halt_a), .i_acc(acc_a), .i_tx_done(done_a),
        .o_tx_start(start_a), .o_tx_data(data_a), .o_busy(busy_a), .o_frame_done(fd_a)
    );

    acc_frame_sequencer #(.NBITS_D(11)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_halt(halt_b), .i_acc(acc_b), .i_tx_done(done_b),
        .o_tx_start(start_b), .o_tx_data(data_b), .o_busy(busy_b), .o_frame_done(fd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the active DUT mid-cycle.
    always @(negedge clk) begin
        if (cur_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(cur_data);
            if (prev_start) dbl <= dbl + 1;
        end
        prev_start <= cur_start;
        if (resp) begin
            dn_cyc.push_back(cyc);
            dn_dat.push_back(cur_data);
        end
        if (cur_fd) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    // uart_tx stand-in: done pulse dly cycles after each start (dly==0 means random).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp = 1'b1;
            end else if (cur_start) begin
                cnt = (dly == 0) ? int'($urandom_range(1, 30)) : dly;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slot();
        @(posedge clk);
        #2;
    endtask

    task automatic set_halt(input logic v);
        if (cur) halt_b = v;
        else     halt_a = v;
    endtask

    task automatic set_acc(input logic [15:0] v);
        if (cur) acc_b = v[10:0];
        else     acc_a = v;
    endtask

    // Reference frame: header, width-masked accumulator bytes LSB first, XOR of all before it.
    task automatic build_exp(input logic [15:0] v, input int nbits);
        int         m;
        int         nb;
        logic [7:0] b;
        logic [7:0] cs;
        exp_q.delete();
        nb = (nbits + 7) / 8;
        m  = int'(v) & ((1 << nbits) - 1);
        cs = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < nb; k++) begin
            b = 8'((m >> (8 * k)) & 255);
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic start_frame(input logic [15:0] v, output int hc);
        set_halt(1'b0);
        slot();
        set_acc(v);
        set_halt(1'b1);
        hc = cyc;
    endtask

    task automatic finish_frame(input string tag, input int hc, input logic [15:0] v,
                                input int s0, input int d0, input int f0);
        int n;
        int exp_cyc;
        n = 0;
        while (fd_cnt == f0 && n < 5000) begin
            slot();
            n++;
        end
        build_exp(v, cur ? 11 : 16);
        check({tag, "_frame_done_cnt"}, 32'(fd_cnt - f0), 1);
        check({tag, "_busy_after"}, 32'(cur_busy), 0);
        check({tag, "_start_cnt"}, 32'(st_cyc.size() - s0), 32'(exp_q.size()));
        check({tag, "_done_cnt"}, 32'(dn_cyc.size() - d0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (s0 + i < st_dat.size()) ? 32'(st_dat[s0 + i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
            check($sformatf("%s_hold%0d", tag, i),
                  (d0 + i < dn_dat.size()) ? 32'(dn_dat[d0 + i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
            if (i == 0) exp_cyc = hc + 1;
            else        exp_cyc = (d0 + i - 1 < dn_cyc.size()) ? dn_cyc[d0 + i - 1] + 1 : -1;
            check($sformatf("%s_start_cyc%0d", tag, i),
                  (s0 + i < st_cyc.size()) ? 32'(st_cyc[s0 + i]) : 32'hDEAD_BEEF, 32'(exp_cyc));
        end
        exp_cyc = (dn_cyc.size() > 0) ? dn_cyc[dn_cyc.size() - 1] + 1 : -1;
        check({tag, "_fd_cyc"}, 32'(fd_cyc), 32'(exp_cyc));
        check({tag, "_double_start"}, 32'(dbl), 0);
    endtask

    initial begin
        int            hc;
        int            s0;
        int            d0;
        int            f0;
        int            n;
        logic [15:0]   v;

        repeat (3) slot();
        check("rst_start", 32'(start_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_fd", 32'(fd_a), 0);
        check("rst_data", 32'(data_a), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        rst = 1'b0;
        repeat (2) slot();

        // Basic frame with fixed 20-cycle uart latency.
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        start_frame(16'h1234, hc);
        finish_frame("t1", hc, 16'h1234, s0, d0, f0);

        // Spurious done while idle.
        s0 = st_cyc.size();
        spur = 1'b1; slot(); spur = 1'b0;
        repeat (5) slot();
        check("t6_idle_starts", 32'(st_cyc.size() - s0), 0);
        check("t6_idle_busy", 32'(busy_a), 0);

        // Spurious done during SEND.
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        start_frame(16'hC3E1, hc);
        slot();
        check("t6_in_send", 32'(start_a), 1);
        spur = 1'b1; slot(); spur = 1'b0;
        finish_frame("t6", hc, 16'hC3E1, s0, d0, f0);

        // Halt re-rise and ACC change mid-frame.
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        start_frame(16'h5A3C, hc);
        repeat (30) slot();
        set_halt(1'b0);
        repeat (3) slot();
        set_acc(16'hFFFF);
        set_halt(1'b1);
        finish_frame("t4", hc, 16'h5A3C, s0, d0, f0);
        repeat (100) slot();
        check("t4_no_second", 32'(st_cyc.size() - s0), 4);
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        start_frame(16'hFFFF, hc);
        finish_frame("t4b", hc, 16'hFFFF, s0, d0, f0);

        // Random accumulators and uart latencies.
        dly = 0;
        for (int r = 0; r < 5; r++) begin
            v = 16'($urandom);
            s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
            start_frame(v, hc);
            finish_frame($sformatf("rnd%0d", r), hc, v, s0, d0, f0);
        end

        // Reset during WAIT of the second byte with halt held high.
        dly = 20;
        s0 = st_cyc.size();
        start_frame(16'hBEEF, hc);
        n = 0;
        while (st_cyc.size() < s0 + 2 && n < 500) begin
            slot();
            n++;
        end
        check("t5_reached_byte2", 32'(st_cyc.size() - s0), 2);
        repeat (5) slot();
        rst = 1'b1;
        #1;
        check("t5_rst_start", 32'(start_a), 0);
        check("t5_rst_busy", 32'(busy_a), 0);
        check("t5_rst_fd", 32'(fd_a), 0);
        check("t5_rst_data", 32'(data_a), 0);
        repeat (3) slot();
        set_acc(16'h0F0F);
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        rst = 1'b0;
        hc = cyc;
        finish_frame("t5", hc, 16'h0F0F, s0, d0, f0);

        // 11-bit accumulator: top data byte zero-padded.
        repeat (40) slot();
        cur = 1'b1;
        slot();
        s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
        start_frame(16'h07FF, hc);
        finish_frame("t3", hc, 16'h07FF, s0, d0, f0);
        dly = 0;
        for (int r = 0; r < 3; r++) begin
            v = 16'($urandom);
            s0 = st_cyc.size(); d0 = dn_cyc.size(); f0 = fd_cnt;
            start_frame(v, hc);
            finish_frame($sformatf("rndb%0d", r), hc, v, s0, d0, f0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
